// File: rtl/cpu7_dtlb_dmw_pkg.sv
// Shared definitions for the data-side DMW translator: CSR addresses, shadow
// field layouts, exception code and FSM states.
package cpu7_dtlb_dmw_pkg;

    localparam logic [13:0] CSR_CRMD = 14'h000;
    localparam logic [13:0] CSR_DMW0 = 14'h180;
    localparam logic [13:0] CSR_DMW1 = 14'h181;

    localparam logic [5:0] EXC_TLBR = 6'h3F;

    localparam int unsigned CRMD_PLV_LO  = 0;
    localparam int unsigned CRMD_DA      = 3;
    localparam int unsigned CRMD_PG      = 4;
    localparam int unsigned CRMD_DATM_LO = 7;

    localparam int unsigned DMW_PLV0     = 0;
    localparam int unsigned DMW_PLV3     = 3;
    localparam int unsigned DMW_MAT_LO   = 4;
    localparam int unsigned DMW_PSEG_LO  = 25;
    localparam int unsigned DMW_VSEG_LO  = 29;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOK = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] datm;
        logic       pg;
        logic       da;
        logic [1:0] plv;
    } crmd_t;

    typedef struct packed {
        logic [2:0] vseg;
        logic [2:0] pseg;
        logic [1:0] mat;
        logic       plv3;
        logic       plv0;
    } dmw_t;

    localparam int unsigned DMW_W = $bits(dmw_t);

    typedef struct packed {
        crmd_t crmd;
        dmw_t  dmw0;
        dmw_t  dmw1;
    } snap_t;

    localparam crmd_t CRMD_RESET = '{datm: 2'b00, pg: 1'b0, da: 1'b1, plv: 2'b00};

    function automatic crmd_t to_crmd(input logic [31:0] w);
        crmd_t c;
        c.datm = w[CRMD_DATM_LO +: 2];
        c.pg   = w[CRMD_PG];
        c.da   = w[CRMD_DA];
        c.plv  = w[CRMD_PLV_LO +: 2];
        return c;
    endfunction

    function automatic dmw_t to_dmw(input logic [31:0] w);
        dmw_t d;
        d.vseg = w[DMW_VSEG_LO +: 3];
        d.pseg = w[DMW_PSEG_LO +: 3];
        d.mat  = w[DMW_MAT_LO +: 2];
        d.plv3 = w[DMW_PLV3];
        d.plv0 = w[DMW_PLV0];
        return d;
    endfunction

endpackage

// File: rtl/cpu7_dmw_match.sv
// Combinational direct-mapped window compare: selects the matching window's
// physical segment and memory access type; DMW0 has priority.
module cpu7_dmw_match
    import cpu7_dtlb_dmw_pkg::*;
(
    input  logic [31:0]      vaddr,
    input  logic [1:0]       plv,
    input  logic [DMW_W-1:0] dmw0,
    input  logic [DMW_W-1:0] dmw1,
    output logic             hit,
    output logic [31:0]      paddr,
    output logic [1:0]       mat
);

    dmw_t w0, w1, sel;
    logic m0, m1;

    // Only PLV0 and PLV3 have enable bits; PLV1/2 never match a window.
    function automatic logic plv_ok(input dmw_t d, input logic [1:0] p);
        return ((p == 2'd0) && d.plv0) || ((p == 2'd3) && d.plv3);
    endfunction

    always_comb begin
        w0    = dmw_t'(dmw0);
        w1    = dmw_t'(dmw1);
        m0    = (vaddr[31:29] == w0.vseg) && plv_ok(w0, plv);
        m1    = (vaddr[31:29] == w1.vseg) && plv_ok(w1, plv);
        sel   = m0 ? w0 : w1;
        hit   = m0 || m1;
        paddr = {sel.pseg, vaddr[28:0]};
        mat   = sel.mat;
    end

endmodule

// File: rtl/cpu7_dtlb_dmw.sv
// Data-side address translator: CSR shadows, DA/DMW lookup, request FSM with
// a one-entry skid buffer and a finish/recv response handshake.
module cpu7_dtlb_dmw
    import cpu7_dtlb_dmw_pkg::*;
#(
    parameter int unsigned GRLEN     = 32,
    parameter int unsigned PABITS    = 32,
    parameter int unsigned CSR_BIT   = 14,
    parameter logic [CSR_BIT-1:0] CRMD_ADDR = CSR_CRMD,
    parameter logic [CSR_BIT-1:0] DMW0_ADDR = CSR_DMW0,
    parameter logic [CSR_BIT-1:0] DMW1_ADDR = CSR_DMW1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               csr_wen,
    input  logic [CSR_BIT-1:0] csr_waddr,
    input  logic [GRLEN-1:0]   csr_wdata,
    input  logic               data_tlb_req,
    input  logic               data_tlb_wr,
    input  logic [GRLEN-1:0]   data_tlb_vaddr,
    input  logic               dtlb_no_trans,
    input  logic               dtlb_cache_recv,
    output logic               dtlb_finish,
    output logic               dtlb_hit,
    output logic [PABITS-1:0]  dtlb_paddr,
    output logic               dtlb_uncache,
    output logic [5:0]         dtlb_exccode
);

    state_t state, state_nxt;

    crmd_t crmd;
    dmw_t  dmw0, dmw1;
    snap_t csr_now;

    logic [GRLEN-1:0] cur_vaddr, skid_vaddr;
    logic             cur_wr, skid_wr;
    logic             cur_nt, skid_nt;
    snap_t            cur_snap, skid_snap;
    logic             skid_valid;

    logic              win_hit;
    logic [31:0]       win_paddr;
    logic [1:0]        win_mat;
    logic              lk_hit, lk_uncache;
    logic [PABITS-1:0] lk_paddr;
    logic [5:0]        lk_exccode;
    logic              draining;

    assign csr_now  = '{crmd: crmd, dmw0: dmw0, dmw1: dmw1};
    assign draining = (state == S_RESP) && dtlb_cache_recv;

    cpu7_dmw_match u_match (
        .vaddr (cur_vaddr[31:0]),
        .plv   (cur_snap.crmd.plv),
        .dmw0  (cur_snap.dmw0),
        .dmw1  (cur_snap.dmw1),
        .hit   (win_hit),
        .paddr (win_paddr),
        .mat   (win_mat)
    );

    always_comb begin
        lk_hit     = 1'b0;
        lk_paddr   = '0;
        lk_uncache = 1'b0;
        lk_exccode = EXC_TLBR;
        if (cur_nt || cur_snap.crmd.da) begin
            lk_hit     = 1'b1;
            lk_paddr   = cur_vaddr[PABITS-1:0];
            lk_uncache = (cur_snap.crmd.datm == 2'd0);
            lk_exccode = '0;
        end else if (win_hit) begin
            lk_hit     = 1'b1;
            lk_paddr   = win_paddr[PABITS-1:0];
            lk_uncache = (win_mat == 2'd0);
            lk_exccode = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (data_tlb_req) state_nxt = S_LOOK;
            S_LOOK: state_nxt = S_RESP;
            S_RESP: begin
                if (dtlb_cache_recv)
                    state_nxt = (skid_valid || data_tlb_req) ? S_LOOK : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd <= CRMD_RESET;
            dmw0 <= '0;
            dmw1 <= '0;
        end else if (csr_wen) begin
            if (csr_waddr == CRMD_ADDR) crmd <= to_crmd(csr_wdata[31:0]);
            if (csr_waddr == DMW0_ADDR) dmw0 <= to_dmw(csr_wdata[31:0]);
            if (csr_waddr == DMW1_ADDR) dmw1 <= to_dmw(csr_wdata[31:0]);
        end
    end

    // Snapshots take the registered CSR state, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_vaddr    <= '0;
            cur_wr       <= 1'b0;
            cur_nt       <= 1'b0;
            cur_snap     <= '0;
            skid_valid   <= 1'b0;
            skid_vaddr   <= '0;
            skid_wr      <= 1'b0;
            skid_nt      <= 1'b0;
            skid_snap    <= '0;
            dtlb_finish  <= 1'b0;
            dtlb_hit     <= 1'b0;
            dtlb_paddr   <= '0;
            dtlb_uncache <= 1'b0;
            dtlb_exccode <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_tlb_req) begin
                        cur_vaddr <= data_tlb_vaddr;
                        cur_wr    <= data_tlb_wr;
                        cur_nt    <= dtlb_no_trans;
                        cur_snap  <= csr_now;
                    end
                end
                S_LOOK: begin
                    dtlb_finish  <= 1'b1;
                    dtlb_hit     <= lk_hit;
                    dtlb_paddr   <= lk_paddr;
                    dtlb_uncache <= lk_uncache;
                    dtlb_exccode <= lk_exccode;
                    if (data_tlb_req && !skid_valid) begin
                        skid_valid <= 1'b1;
                        skid_vaddr <= data_tlb_vaddr;
                        skid_wr    <= data_tlb_wr;
                        skid_nt    <= dtlb_no_trans;
                        skid_snap  <= csr_now;
                    end
                end
                S_RESP: begin
                    if (dtlb_cache_recv) begin
                        dtlb_finish <= 1'b0;
                        if (skid_valid) begin
                            cur_vaddr  <= skid_vaddr;
                            cur_wr     <= skid_wr;
                            cur_nt     <= skid_nt;
                            cur_snap   <= skid_snap;
                            skid_valid <= data_tlb_req;
                            if (data_tlb_req) begin
                                skid_vaddr <= data_tlb_vaddr;
                                skid_wr    <= data_tlb_wr;
                                skid_nt    <= dtlb_no_trans;
                                skid_snap  <= csr_now;
                            end
                        end else if (data_tlb_req) begin
                            cur_vaddr <= data_tlb_vaddr;
                            cur_wr    <= data_tlb_wr;
                            cur_nt    <= dtlb_no_trans;
                            cur_snap  <= csr_now;
                        end
                    end else if (data_tlb_req && !skid_valid) begin
                        skid_valid <= 1'b1;
                        skid_vaddr <= data_tlb_vaddr;
                        skid_wr    <= data_tlb_wr;
                        skid_nt    <= dtlb_no_trans;
                        skid_snap  <= csr_now;
                    end
                end
                default: ;
            endcase
        end
    end

    // A request while the skid entry is occupied and not being drained is dropped.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(data_tlb_req && skid_valid && !draining));

endmodule

// File: tb/tb_cpu7_dtlb_dmw.sv
// Directed self-checking bench for cpu7_dtlb_dmw: DA mode, DMW windows, PLV
// gating, skid buffering, CSR snapshot timing and asynchronous reset.
module tb_cpu7_dtlb_dmw;

    logic        clk;
    logic        resetn;
    logic        csr_wen;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        data_tlb_req;
    logic        data_tlb_wr;
    logic [31:0] data_tlb_vaddr;
    logic        dtlb_no_trans;
    logic        dtlb_cache_recv;
    logic        dtlb_finish;
    logic        dtlb_hit;
    logic [31:0] dtlb_paddr;
    logic        dtlb_uncache;
    logic [5:0]  dtlb_exccode;

    int checks = 0;
    int errors = 0;

    cpu7_dtlb_dmw #(
        .GRLEN   (32),
        .PABITS  (32),
        .CSR_BIT (14)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .csr_wen         (csr_wen),
        .csr_waddr       (csr_waddr),
        .csr_wdata       (csr_wdata),
        .data_tlb_req    (data_tlb_req),
        .data_tlb_wr     (data_tlb_wr),
        .data_tlb_vaddr  (data_tlb_vaddr),
        .dtlb_no_trans   (dtlb_no_trans),
        .dtlb_cache_recv (dtlb_cache_recv),
        .dtlb_finish     (dtlb_finish),
        .dtlb_hit        (dtlb_hit),
        .dtlb_paddr      (dtlb_paddr),
        .dtlb_uncache    (dtlb_uncache),
        .dtlb_exccode    (dtlb_exccode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [13:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        tick();
        csr_wen   = 1'b0;
    endtask

    // Issue one request from IDLE; returns with the response on the outputs.
    task automatic issue(input string tag, input logic [31:0] va, input logic nt);
        data_tlb_req   = 1'b1;
        data_tlb_vaddr = va;
        dtlb_no_trans  = nt;
        data_tlb_wr    = va[2];
        tick();
        data_tlb_req   = 1'b0;
        dtlb_no_trans  = 1'b0;
        chk({tag, "_look_finish"}, {31'd0, dtlb_finish}, 32'd0);
        tick();
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] pa, input logic hit,
                               input logic unc, input logic [5:0] exc);
        chk({tag, "_finish"},  {31'd0, dtlb_finish}, 32'd1);
        chk({tag, "_hit"},     {31'd0, dtlb_hit}, {31'd0, hit});
        chk({tag, "_paddr"},   dtlb_paddr, pa);
        chk({tag, "_uncache"}, {31'd0, dtlb_uncache}, {31'd0, unc});
        chk({tag, "_exccode"}, {26'd0, dtlb_exccode}, {26'd0, exc});
    endtask

    initial begin
        resetn          = 1'b0;
        csr_wen         = 1'b0;
        csr_waddr       = '0;
        csr_wdata       = '0;
        data_tlb_req    = 1'b0;
        data_tlb_wr     = 1'b0;
        data_tlb_vaddr  = '0;
        dtlb_no_trans   = 1'b0;
        dtlb_cache_recv = 1'b1;

        tick();
        tick();
        chk("rst_finish",  {31'd0, dtlb_finish}, 32'd0);
        chk("rst_hit",     {31'd0, dtlb_hit}, 32'd0);
        chk("rst_paddr",   dtlb_paddr, 32'd0);
        chk("rst_exccode", {26'd0, dtlb_exccode}, 32'd0);
        resetn = 1'b1;
        tick();

        // DA mode after reset, DATM=0 -> uncached identity
        issue("da", 32'h1c000040, 1'b0);
        expect_resp("da", 32'h1c000040, 1'b1, 1'b1, 6'h00);
        tick();
        chk("da_idle_finish", {31'd0, dtlb_finish}, 32'd0);

        // Mapped mode, DMW0: VSEG4 -> PSEG0, MAT1, PLV0
        csr_write(14'h000, 32'h00000010);
        csr_write(14'h180, 32'h80000011);
        issue("dmw0", 32'h80001234, 1'b0);
        expect_resp("dmw0", 32'h00001234, 1'b1, 1'b0, 6'h00);
        tick();

        // Mapped mode with no windows -> refill
        csr_write(14'h180, 32'h00000000);
        issue("miss", 32'h00400000, 1'b0);
        expect_resp("miss", 32'h00000000, 1'b0, 1'b0, 6'h3F);
        tick();

        // DMW1: VSEG5 -> PSEG1, MAT0, PLV0|PLV3
        csr_write(14'h180, 32'h80000011);
        csr_write(14'h181, 32'ha2000009);
        issue("dmw1", 32'ha0000044, 1'b0);
        expect_resp("dmw1", 32'h20000044, 1'b1, 1'b1, 6'h00);
        tick();

        // Both windows map VSEG4: DMW0 wins at PLV0
        csr_write(14'h181, 32'h86000019);
        issue("prio", 32'h80000100, 1'b0);
        expect_resp("prio", 32'h00000100, 1'b1, 1'b0, 6'h00);
        tick();

        // PLV3: DMW0 lacks PLV3 enable, DMW1 (PSEG3) matches
        csr_write(14'h000, 32'h00000013);
        issue("plv3", 32'h80000100, 1'b0);
        expect_resp("plv3", 32'h60000100, 1'b1, 1'b0, 6'h00);
        tick();

        // PLV1 never matches
        csr_write(14'h000, 32'h00000011);
        issue("plv1", 32'h80000100, 1'b0);
        expect_resp("plv1", 32'h00000000, 1'b0, 1'b0, 6'h3F);
        tick();

        // Back pressure with a buffered second request
        csr_write(14'h000, 32'h00000010);
        dtlb_cache_recv = 1'b0;
        data_tlb_req    = 1'b1;
        data_tlb_vaddr  = 32'h80000010;
        tick();
        data_tlb_vaddr  = 32'h80000020;
        tick();
        data_tlb_req    = 1'b0;
        expect_resp("hold0", 32'h00000010, 1'b1, 1'b0, 6'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_finish", {31'd0, dtlb_finish}, 32'd1);
            chk("hold_paddr", dtlb_paddr, 32'h00000010);
        end
        dtlb_cache_recv = 1'b1;
        tick();
        tick();
        expect_resp("skid", 32'h00000020, 1'b1, 1'b0, 6'h00);
        // req together with recv goes straight to lookup
        data_tlb_req   = 1'b1;
        data_tlb_vaddr = 32'h80000030;
        tick();
        data_tlb_req   = 1'b0;
        tick();
        expect_resp("direct", 32'h00000030, 1'b1, 1'b0, 6'h00);
        tick();
        chk("direct_idle_finish", {31'd0, dtlb_finish}, 32'd0);

        // CSR write in the accept cycle is not seen by that request
        csr_wen        = 1'b1;
        csr_waddr      = 14'h180;
        csr_wdata      = 32'h82000011;
        data_tlb_req   = 1'b1;
        data_tlb_vaddr = 32'h80000100;
        tick();
        csr_wen        = 1'b0;
        data_tlb_req   = 1'b0;
        tick();
        expect_resp("snap_old", 32'h00000100, 1'b1, 1'b0, 6'h00);
        tick();
        issue("snap_new", 32'h80000100, 1'b0);
        expect_resp("snap_new", 32'h20000100, 1'b1, 1'b0, 6'h00);
        tick();
        issue("notrans", 32'h80000100, 1'b1);
        expect_resp("notrans", 32'h80000100, 1'b1, 1'b1, 6'h00);
        tick();

        // Asynchronous reset while a response is held
        dtlb_cache_recv = 1'b0;
        issue("pre_rst", 32'h80000100, 1'b0);
        expect_resp("pre_rst", 32'h20000100, 1'b1, 1'b0, 6'h00);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_finish", {31'd0, dtlb_finish}, 32'd0);
        chk("arst_paddr", dtlb_paddr, 32'd0);
        chk("arst_hit", {31'd0, dtlb_hit}, 32'd0);
        tick();
        resetn = 1'b1;
        dtlb_cache_recv = 1'b1;
        tick();
        issue("post_da", 32'h80001234, 1'b0);
        expect_resp("post_da", 32'h80001234, 1'b1, 1'b1, 6'h00);
        tick();
        // DMW0 cleared by reset: mapped lookup now misses
        csr_write(14'h000, 32'h00000010);
        issue("post_dmw", 32'h80001234, 1'b0);
        expect_resp("post_dmw", 32'h00000000, 1'b0, 1'b0, 6'h3F);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
